mac_vec: RTL
============

Name: mac_vec

Overview:
- Multi-lane, pipelined successor to the single-lane MAC.
- Each accepted beat carries LANES A/B operand pairs. The block multiplies them pairwise, sums the products and accumulates the sum over a programmable number of beats.
- It returns one result per job through a valid/ready output handshake.
- Sits between the operand-fetch FSM and the result writeback path in the minilab datapath.

Parameters:
- DATA_WIDTH, 8, width of each A/B lane operand.
- LANES, 4, operand pairs per beat (power of 2, >=1).
- ACC_WIDTH, DATA_WIDTH*3, accumulator/result width.
- CNT_WIDTH, 8, width of the beat-count field.
- SIGNED, 0, 1 = two's-complement operands and accumulator; 0 = unsigned.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- len  in  CNT_WIDTH  beats in the job; latched on start.
- clr  in  1  synchronous abort; clears the job.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  LANES*DATA_WIDTH  packed A lanes, lane 0 in the LSBs.
- b  in  LANES*DATA_WIDTH  packed B lanes, lane 0 in the LSBs.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  ACC_WIDTH  accumulated dot product.
- overflow  out  1  sticky; the accumulator exceeded its range during this job.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Decided interface: one clock, clk; reset is synchronous and active-high on port rst.
- Reset values: state=IDLE, in_ready=0, out_valid=0, result=0, overflow=0, busy=0, pipeline valid bits=0, accumulator=0.
- Priority per cycle: rst > clr > normal operation.
- clr in any state:
  - State goes to IDLE; accumulator, pipeline, result, out_valid and overflow are cleared next cycle.
  - A start in the same cycle as clr is ignored.
- States:
  - IDLE: in_ready=0.
    - start=1 and len!=0: latch len into the beat counter, clear accumulator and overflow, go to RUN.
    - start=1 and len==0: clear result to 0, go to DONE (out_valid=1 next cycle).
  - RUN: in_ready=1. A beat is accepted when in_valid&&in_ready.
    - Each accepted beat decrements the counter.
    - On the beat that brings the counter to 0, go to DRAIN; in_ready drops the next cycle.
  - DRAIN: in_ready=0. Wait until both pipeline stages are empty, then copy the accumulator to result and go to DONE.
  - DONE: out_valid=1, result held stable.
    - out_valid&&out_ready: go to IDLE, out_valid=0 next cycle.
    - start is ignored in DONE.
- Pipeline:
  - S1 registers the LANES products of the accepted beat.
  - S2 adds the products in an adder tree and adds the sum into the accumulator.
  - Accepted beats advance every cycle; there are no bubbles.
- Latency: last beat accepted at posedge N -> out_valid first high after posedge N+3 (S1 at N+1, accumulate at N+2, result/DONE at N+3).
- Widths:
  - Product is 2*DATA_WIDTH.
  - Tree sum is 2*DATA_WIDTH+$clog2(LANES).
  - The sum is zero- or sign-extended (per SIGNED) to ACC_WIDTH+1 before the add.
- Overflow:
  - Unsigned: carry out of ACC_WIDTH.
  - Signed: operands have the same sign and the result sign differs.
  - The overflow flag is set on any overflowing add and stays set until the next start or clr.
- Without saturation the accumulator wraps mod 2^ACC_WIDTH.
- in_valid while in_ready=0 is ignored; no data is lost because the producer holds the beat.

Optional Feature:
- Macro: MAC_VEC_SAT_EN.
- Defined: on overflow the accumulator clamps and stays clamped for the rest of the job, with overflow still asserted.
  - Unsigned: clamps to 2^ACC_WIDTH-1.
  - Signed: clamps to 2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1), per the direction of overflow.
- Undefined: wrap-around as above, no clamp logic synthesised.

Decomposition:
- Package mac_vec_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - localparams PROD_W=2*DATA_WIDTH and SUM_W=PROD_W+$clog2(LANES);
  - the extend/saturate helper function.
- One sub-module, mac_vec_tree: registered LANES-input multiplier stage plus combinational adder tree, with a SIGNED parameter.
- Top level keeps the FSM, counter, accumulator and handshake.

Test Plan:
- Reset hold:
  - Hold rst 5 cycles with in_valid=1 and start=1 -> all outputs 0, busy=0.
  - Release rst, keep start=0 -> in_ready stays 0.
- Basic job, defaults:
  - len=3; every lane a=2, b=3 for all beats -> result=72 (0x000048).
  - out_valid 3 cycles after the last accept; overflow=0.
- Backpressure:
  - Same job, in_valid toggling 1/0 each cycle -> result=72.
  - Hold out_ready=0 for 4 cycles -> result and out_valid stable; they drop the cycle after out_ready=1.
- Signed and len==0:
  - SIGNED=1: lanes a={-1,2,-3,4}, b={5,5,5,5}, len=2 -> result=20.
  - start with len=0 -> out_valid next cycle, result=0.
- Overflow, LANES=1, DATA_WIDTH=8, ACC_WIDTH=16: len=2, a=b=255 -> overflow=1.
  - Without MAC_VEC_SAT_EN: result=0xFC02.
  - With MAC_VEC_SAT_EN: result=0xFFFF.
- Abort: clr asserted mid-RUN after 2 of 5 beats -> IDLE next cycle, out_valid never asserted, next job len=1 (a=b=1 per lane, LANES=4) gives result=4.

Source files
------------

// File: rtl/mac_vec_pkg.sv
// Shared types and width helpers for the mac_vec dot-product accumulator.
// Default-configuration widths and the accumulator clamp helper live here.
package mac_vec_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_LANES      = 4;
  localparam int PROD_W         = 2 * DEF_DATA_WIDTH;
  localparam int SUM_W          = PROD_W + $clog2(DEF_LANES);

  // Clamp value for a w-bit accumulator: unsigned max, or signed max/min.
  function automatic logic [63:0] sat_limit(input int w, input bit is_signed, input bit neg);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    if (is_signed) m = neg ? ~(m >> 1) : (m >> 1);
    return m;
  endfunction

endpackage

// File: rtl/mac_vec_tree.sv
// Registered LANES-wide multiplier stage feeding a combinational adder tree.
// Latency: products registered 1 cycle after an accepted beat; sum is combinational.
// Backpressure: none; every accepted beat advances, clr/rst flush the stage.
module mac_vec_tree
  import mac_vec_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int SIGNED     = 0,
  parameter int PW         = PROD_W,
  parameter int SW         = SUM_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        in_vld,
  input  logic [LANES*DATA_WIDTH-1:0] a,
  input  logic [LANES*DATA_WIDTH-1:0] b,
  output logic                        s1_vld,
  output logic [SW-1:0]               sum
);

  logic [PW-1:0] prod_d [LANES];
  logic [PW-1:0] prod_q [LANES];
  logic [PW-1:0] xa, xb;
  logic [SW-1:0] ext;

  always_comb begin
    xa = '0;
    xb = '0;
    for (int i = 0; i < LANES; i++) begin
      xa = '0;
      xb = '0;
      xa[DATA_WIDTH-1:0] = a[i*DATA_WIDTH +: DATA_WIDTH];
      xb[DATA_WIDTH-1:0] = b[i*DATA_WIDTH +: DATA_WIDTH];
      for (int j = DATA_WIDTH; j < PW; j++) begin
        xa[j] = (SIGNED != 0) && a[i*DATA_WIDTH+DATA_WIDTH-1];
        xb[j] = (SIGNED != 0) && b[i*DATA_WIDTH+DATA_WIDTH-1];
      end
      // Low PW bits of the product are exact for both encodings once extended.
      prod_d[i] = xa * xb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s1_vld <= 1'b0;
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
    end else begin
      s1_vld <= in_vld;
      if (in_vld) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  always_comb begin
    sum = '0;
    ext = '0;
    for (int i = 0; i < LANES; i++) begin
      ext = '0;
      ext[PW-1:0] = prod_q[i];
      for (int j = PW; j < SW; j++) ext[j] = (SIGNED != 0) && prod_q[i][PW-1];
      sum = sum + ext;
    end
  end

endmodule

// File: rtl/mac_vec.sv
// Multi-lane MAC: per-beat dot product accumulated over len beats, one result per job.
// Latency: last beat accepted at posedge N gives out_valid after posedge N+3.
// Backpressure: in_ready only in RUN; result held in DONE until out_ready. MAC_VEC_SAT_EN clamps on overflow.
module mac_vec
  import mac_vec_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int ACC_WIDTH  = DATA_WIDTH * 3,
  parameter int CNT_WIDTH  = 8,
  parameter int SIGNED     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        len,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] a,
  input  logic [LANES*DATA_WIDTH-1:0] b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ACC_WIDTH-1:0]        result,
  output logic                        overflow,
  output logic                        busy
);

  localparam int P_W = 2 * DATA_WIDTH;
  localparam int S_W = P_W + $clog2(LANES);
  localparam int AW1 = ACC_WIDTH + 1;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_nxt, result_q;
  logic                 ovf_q, s2_vld_q, s1_vld, fire, add_ovf;
  logic [S_W-1:0]       tree_sum;
  logic [AW1-1:0]       acc_x, sum_x, add_x;

  assign in_ready  = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign fire      = in_valid && in_ready;

  mac_vec_tree #(
    .DATA_WIDTH(DATA_WIDTH),
    .LANES     (LANES),
    .SIGNED    (SIGNED),
    .PW        (P_W),
    .SW        (S_W)
  ) u_tree (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .in_vld(fire),
    .a     (a),
    .b     (b),
    .s1_vld(s1_vld),
    .sum   (tree_sum)
  );

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = (len != '0) ? RUN : DONE;
        RUN:     if (fire && cnt_q == CNT_WIDTH'(1)) state_d = DRAIN;
        DRAIN:   if (!s1_vld && !s2_vld_q) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // One extra bit of headroom exposes the unsigned carry and signed sign flip.
  always_comb begin
    acc_x = {(SIGNED != 0) && acc_q[ACC_WIDTH-1], acc_q};
    sum_x = '0;
    sum_x[S_W-1:0] = tree_sum;
    for (int j = S_W; j < AW1; j++) sum_x[j] = (SIGNED != 0) && tree_sum[S_W-1];
    add_x = acc_x + sum_x;
    if (SIGNED != 0)
      add_ovf = (acc_x[ACC_WIDTH-1] == sum_x[ACC_WIDTH-1]) &&
                (add_x[ACC_WIDTH-1] != acc_x[ACC_WIDTH-1]);
    else
      add_ovf = add_x[ACC_WIDTH];
    acc_nxt = add_x[ACC_WIDTH-1:0];
`ifdef MAC_VEC_SAT_EN
    if (ovf_q)
      acc_nxt = acc_q;
    else if (add_ovf)
      acc_nxt = ACC_WIDTH'(sat_limit(ACC_WIDTH, SIGNED != 0, acc_q[ACC_WIDTH-1]));
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld;
      if (fire) cnt_q <= cnt_q - CNT_WIDTH'(1);
      if (s1_vld) begin
        acc_q <= acc_nxt;
        if (add_ovf) ovf_q <= 1'b1;
      end
      if (state_q == DRAIN && state_d == DONE) result_q <= acc_q;
      if (state_q == IDLE && start) begin
        ovf_q <= 1'b0;
        if (len != '0) begin
          cnt_q <= len;
          acc_q <= '0;
        end else begin
          result_q <= '0;
        end
      end
    end
  end

endmodule
